vram_dump: RTL and testbench

VRAM_DUMP -- requirements
Module: vram_dump

---
 rtl/vram_dump.sv | 148 ++++++++++++++
 tb/tb_vram_dump.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_dump.sv
// Screen dump engine: walks a COLS x ROWS text VRAM and streams each character,
// with CR/LF after every row, out of an 8N1 UART transmitter.
module vram_dump #(
  parameter int COLS   = 60,
  parameter int ROWS   = 17,
  parameter int CLK_HZ = 24_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_running,
  output logic        o_done,
  output logic [10:0] o_vram_addr,
  output logic        o_vram_ce,
  output logic        o_vram_w,
  input  logic [7:0]  i_vram_dout,
  output logic        o_tx
);

  // BIT_DIV must be at least 2 for the bit timing below to make sense.
  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int DIV_W   = (BIT_DIV < 2) ? 1 : $clog2(BIT_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [5:0]       X_LAST   = 6'(COLS - 1);
  localparam logic [4:0]       Y_LAST   = 5'(ROWS - 1);
  localparam logic [3:0]       STOP_BIT = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND,
    CR,
    LF,
    DONE
  } state_t;

  state_t           state;
  logic [5:0]       x;
  logic [4:0]       y;
  logic [DIV_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [8:0]       shifter;   // {stop, data[7:0]}, shifted out LSB first
  logic [7:0]       char_byte;

  assign o_vram_w = 1'b0;

  // Non-printable bytes are shown as '.' on the terminal.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    char_byte = i_vram_dout;
    if (i_vram_dout < 8'h20 || i_vram_dout > 8'h7E) char_byte = 8'h2E;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shifter     <= '1;
      o_tx        <= 1'b1;
      o_running   <= 1'b0;
      o_done      <= 1'b0;
      o_vram_ce   <= 1'b0;
      o_vram_addr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; these defaults are overridden below.
      o_vram_ce   <= 1'b0;
      o_vram_addr <= '0;
      o_done      <= 1'b0;

      unique case (state)
        IDLE: begin
          if (i_start) begin
            x           <= '0;
            y           <= '0;
            state       <= READ;
            o_running   <= 1'b1;
            o_vram_ce   <= 1'b1;
            o_vram_addr <= '0;
          end
        end

        READ: state <= CAPTURE;

        CAPTURE: begin
          shifter  <= {1'b1, char_byte};
          baud_cnt <= '0;
          bit_cnt  <= '0;
          o_tx     <= 1'b0;
          state    <= SEND;
        end

        SEND, CR, LF: begin
          if (baud_cnt != DIV_LAST) begin
            baud_cnt <= baud_cnt + 1'b1;
          end else if (bit_cnt != STOP_BIT) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
            o_tx     <= shifter[0];
            shifter  <= {1'b1, shifter[8:1]};
          end else begin
            // Frame complete: start the next frame or READ with no idle cycle.
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (state == SEND) begin
              if (x < X_LAST) begin
                x           <= x + 6'd1;
                state       <= READ;
                o_vram_ce   <= 1'b1;
                o_vram_addr <= {y, x + 6'd1};
              end else begin
                shifter <= {1'b1, 8'h0D};
                o_tx    <= 1'b0;
                state   <= CR;
              end
            end else if (state == CR) begin
              shifter <= {1'b1, 8'h0A};
              o_tx    <= 1'b0;
              state   <= LF;
            end else if (y < Y_LAST) begin
              x           <= '0;
              y           <= y + 5'd1;
              state       <= READ;
              o_vram_ce   <= 1'b1;
              o_vram_addr <= {y + 5'd1, 6'd0};
            end else begin
              state  <= DONE;
              o_done <= 1'b1;
            end
          end
        end

        DONE: begin
          state     <= IDLE;
          o_running <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_dump.sv
// Bench for vram_dump: four instances with different geometries, each with a VRAM
// model, a UART frame decoder and ce/done monitors; directed tests run one at a time.
module tb_vram_dump;

  localparam int N = 4;
  localparam int COLS_A [N] = '{2, 3, 8, 60};
  localparam int ROWS_A [N] = '{1, 2, 1, 17};
  localparam int HZ_A   [N] = '{16, 8, 16, 8};
  localparam int BAUD_A [N] = '{4, 4, 4, 4};
  localparam int BD_A   [N] = '{4, 2, 4, 2};

  logic         clk = 1'b0;
  logic [N-1:0] rst_v;
  logic [N-1:0] start_v;
  logic [N-1:0] clr_v;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_mon
    localparam int BD = BD_A[g];

    logic        running, done, ce, w, tx;
    logic [10:0] addr;
    logic [7:0]  dout = '0;
    logic [7:0]  mem [2048];
    logic [7:0]  rx_q [$];
    logic [10:0] addr_q [$];
    int          ferr = 0, ce_err = 0, w_err = 0, done_n = 0;
    int          t_first = -1, t_done = -1, rx_cnt = 0;
    logic        rx_busy = 1'b0, ce_prev = 1'b0;
    logic [7:0]  rx_sh = '0;

    vram_dump #(
      .COLS  (COLS_A[g]),
      .ROWS  (ROWS_A[g]),
      .CLK_HZ(HZ_A[g]),
      .BAUD  (BAUD_A[g])
    ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst_v[g]),
      .i_start    (start_v[g]),
      .o_running  (running),
      .o_done     (done),
      .o_vram_addr(addr),
      .o_vram_ce  (ce),
      .o_vram_w   (w),
      .i_vram_dout(dout),
      .o_tx       (tx)
    );

    // Synchronous-read VRAM: data appears the cycle after ce.
    always @(posedge clk) if (ce) dout <= mem[addr];

    always @(negedge clk) begin
      if (clr_v[g]) begin
        rx_q.delete();
        addr_q.delete();
        ferr    <= 0;
        ce_err  <= 0;
        w_err   <= 0;
        done_n  <= 0;
        t_first <= -1;
        t_done  <= -1;
      end else begin
        if (ce) begin
          addr_q.push_back(addr);
          if (t_first < 0) t_first <= cyc;
        end
        if ((ce && ce_prev) || (!ce && addr != 11'h000)) ce_err <= ce_err + 1;
        if (w !== 1'b0) w_err <= w_err + 1;
        if (done) begin
          done_n <= done_n + 1;
          t_done <= cyc;
        end
      end
      ce_prev <= ce;

      // UART decoder: sample each bit in its middle cycle.
      if (rst_v[g]) begin
        rx_busy <= 1'b0;
        rx_cnt  <= 0;
      end else if (!rx_busy) begin
        if (tx == 1'b0) begin
          rx_busy <= 1'b1;
          rx_cnt  <= 1;
        end
      end else begin
        if (rx_cnt % BD == BD / 2) begin
          if (rx_cnt / BD == 0) begin
            if (tx !== 1'b0) ferr <= ferr + 1;
          end else if (rx_cnt / BD <= 8) begin
            rx_sh <= {tx, rx_sh[7:1]};
          end else begin
            if (tx !== 1'b1) ferr <= ferr + 1;
            rx_q.push_back(rx_sh);
          end
        end
        if (rx_cnt == 10 * BD - 1) rx_busy <= 1'b0;
        rx_cnt <= rx_cnt + 1;
      end
    end
  end

  typedef struct packed {
    logic [7:0] vram;
    logic [7:0] tx;
  } filt_vec_t;

  filt_vec_t   fv [8];
  logic [10:0] exp_addr [6];
  logic [7:0]  exp_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] printable(input logic [7:0] b);
    if (b < 8'h20 || b > 8'h7E) return 8'h2E;
    return b;
  endfunction

  function automatic logic done_of(input int g);
    case (g)
      0:       return g_mon[0].done;
      1:       return g_mon[1].done;
      2:       return g_mon[2].done;
      default: return g_mon[3].done;
    endcase
  endfunction

  task automatic pulse_start(input int g);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  task automatic clear(input int g);
    clr_v[g] = 1'b1;
    @(negedge clk);
    clr_v[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, input string name);
    int i = 0;
    while (!done_of(g) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(done_of(g)), 64'd1);
  endtask

  task automatic wait_tx_low0(input int budget);
    int i = 0;
    while (g_mon[0].tx && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("start_bit_seen", 64'(g_mon[0].tx), 64'd0);
  endtask

  function automatic logic [31:0] first4_0();
    logic [31:0] word = '0;
    for (int i = 0; i < 4 && i < g_mon[0].rx_q.size(); i++) word = {word[23:0], g_mon[0].rx_q[i]};
    return word;
  endfunction

  initial begin
    int errs;
    int run;

    fv[0] = '{vram: 8'h00, tx: 8'h2E};
    fv[1] = '{vram: 8'h7F, tx: 8'h2E};
    fv[2] = '{vram: 8'hFF, tx: 8'h2E};
    fv[3] = '{vram: 8'h7E, tx: 8'h7E};
    fv[4] = '{vram: 8'h1F, tx: 8'h2E};
    fv[5] = '{vram: 8'h20, tx: 8'h20};
    fv[6] = '{vram: 8'h41, tx: 8'h41};
    fv[7] = '{vram: 8'h80, tx: 8'h2E};
    exp_addr = '{11'h000, 11'h001, 11'h002, 11'h040, 11'h041, 11'h042};

    rst_v   = '1;
    start_v = '0;
    clr_v   = '0;
    for (int a = 0; a < 2048; a++) begin
      g_mon[0].mem[a] = 8'h20;
      g_mon[1].mem[a] = 8'h30 + 8'(a % 10);
      g_mon[2].mem[a] = 8'h20;
      g_mon[3].mem[a] = 8'(a) ^ 8'h5A;
    end
    g_mon[0].mem[0] = 8'h41;
    g_mon[0].mem[1] = 8'h42;
    for (int i = 0; i < 8; i++) g_mon[2].mem[i] = fv[i].vram;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({g_mon[0].tx, g_mon[0].running, g_mon[0].done, g_mon[0].ce, g_mon[0].w, g_mon[0].addr}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000}));
    rst_v = '0;
    clr_v = '1;
    @(negedge clk);
    clr_v = '0;
    repeat (5) @(negedge clk);
    check("idle_without_start", 64'({g_mon[0].running, g_mon[0].tx}), 64'({1'b0, 1'b1}));

    // Basic 2x1 dump.
    pulse_start(0);
    check("basic_first_read", 64'({g_mon[0].running, g_mon[0].ce, g_mon[0].addr}), 64'({1'b1, 1'b1, 11'h000}));
    wait_done(0, 400, "basic_done");
    repeat (3) @(negedge clk);
    check("basic_frames", 64'(g_mon[0].rx_q.size()), 64'd4);
    check("basic_bytes", 64'(first4_0()), 64'h41420D0A);
    check("basic_done_pulses", 64'(g_mon[0].done_n), 64'd1);
    check("basic_cycles", 64'(g_mon[0].t_done - g_mon[0].t_first + 1), 64'd165);
    check("basic_idle_after", 64'(g_mon[0].running), 64'd0);
    check("basic_framing", 64'(g_mon[0].ferr), 64'd0);

    // Start while busy: during SEND and again in the DONE cycle.
    clear(0);
    pulse_start(0);
    wait_tx_low0(20);
    repeat (10) @(negedge clk);
    pulse_start(0);
    wait_done(0, 400, "busy_done");
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (200) @(negedge clk);
    check("busy_done_pulses", 64'(g_mon[0].done_n), 64'd1);
    check("busy_ce_count", 64'(g_mon[0].addr_q.size()), 64'd2);
    check("busy_frames", 64'(g_mon[0].rx_q.size()), 64'd4);
    check("busy_idle", 64'(g_mon[0].running), 64'd0);

    // Reset during data bit 3 of the first character.
    clear(0);
    pulse_start(0);
    wait_tx_low0(20);
    repeat (17) @(negedge clk);
    check("rst_data_bit3", 64'(g_mon[0].tx), 64'd0);
    #1 rst_v[0] = 1'b1;
    #1 check("rst_async_outputs", 64'({g_mon[0].tx, g_mon[0].running, g_mon[0].ce}), 64'({1'b1, 1'b0, 1'b0}));
    repeat (4) @(negedge clk);
    rst_v[0] = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_no_more_ce", 64'(g_mon[0].addr_q.size()), 64'd1);
    check("rst_stays_idle", 64'({g_mon[0].running, g_mon[0].tx}), 64'({1'b0, 1'b1}));
    pulse_start(0);
    check("rst_restart_addr", 64'({g_mon[0].ce, g_mon[0].addr}), 64'({1'b1, 11'h000}));
    wait_done(0, 400, "rst_done");
    repeat (3) @(negedge clk);
    check("rst_restart_bytes", 64'(first4_0()), 64'h41420D0A);
    check("rst_done_pulses", 64'(g_mon[0].done_n), 64'd1);

    // Addressing on a 3x2 screen.
    pulse_start(1);
    wait_done(1, 400, "addr_done");
    repeat (3) @(negedge clk);
    check("addr_ce_count", 64'(g_mon[1].addr_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < g_mon[1].addr_q.size(); i++)
      check($sformatf("addr_%0d", i), 64'(g_mon[1].addr_q[i]), 64'(exp_addr[i]));
    check("addr_ce_single_cycle", 64'(g_mon[1].ce_err), 64'd0);
    check("addr_w_low", 64'(g_mon[1].w_err), 64'd0);
    check("addr_frames", 64'(g_mon[1].rx_q.size()), 64'd10);

    // Character filtering, table driven.
    pulse_start(2);
    wait_done(2, 600, "filter_done");
    repeat (3) @(negedge clk);
    check("filter_frames", 64'(g_mon[2].rx_q.size()), 64'd10);
    for (int i = 0; i < 8 && i < g_mon[2].rx_q.size(); i++)
      check($sformatf("filter_%0d_in_%0h", i, fv[i].vram), 64'(g_mon[2].rx_q[i]), 64'(fv[i].tx));
    if (g_mon[2].rx_q.size() == 10)
      check("filter_crlf", 64'({g_mon[2].rx_q[8], g_mon[2].rx_q[9]}), 64'h0D0A);

    // Default geometry 60x17 with a fast bit rate.
    pulse_start(3);
    wait_done(3, 30000, "big_done");
    repeat (3) @(negedge clk);
    for (int y = 0; y < 17; y++) begin
      for (int x = 0; x < 60; x++) exp_q.push_back(printable(g_mon[3].mem[y * 64 + x]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    check("big_frames", 64'(g_mon[3].rx_q.size()), 64'd1054);
    errs = 0;
    for (int i = 0; i < exp_q.size() && i < g_mon[3].rx_q.size(); i++)
      if (g_mon[3].rx_q[i] !== exp_q[i]) errs++;
    check("big_stream_errors", 64'(errs), 64'd0);
    errs = 0;
    run  = 0;
    for (int i = 0; i < g_mon[3].rx_q.size(); i++) begin
      if (g_mon[3].rx_q[i] == 8'h0D) begin
        if (run != 60) errs++;
      end else if (g_mon[3].rx_q[i] == 8'h0A) begin
        run = 0;
      end else begin
        run++;
      end
    end
    check("big_chars_per_cr", 64'(errs), 64'd0);
    errs = 0;
    for (int i = 0; i < g_mon[3].addr_q.size(); i++)
      if (g_mon[3].addr_q[i][5:0] >= 6'd60 || g_mon[3].addr_q[i][10:6] >= 5'd17) errs++;
    check("big_addr_range", 64'(errs), 64'd0);
    check("big_ce_count", 64'(g_mon[3].addr_q.size()), 64'd1020);
    check("big_cycles", 64'(g_mon[3].t_done - g_mon[3].t_first + 1), 64'd23121);
    check("big_framing", 64'(g_mon[3].ferr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
